vec_pack: RTL and testbench

VEC_PACK -- requirements
Module: vec_pack

---
 rtl/vec_pack.sv | 120 ++++++++++++
 tb/tb_vec_pack.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vec_pack.sv
// Collects WIDTH-bit words into DEPTH-word groups and presents each group
// as one registered vector. The word order in the vector depends on the pack mode.
module vec_pack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    input  logic [1:0]                     mode,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH*DEPTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]     out_count
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [1:0]                    mode_q, mode_d;
    logic [DEPTH-1:0][WIDTH-1:0]   slot_q, slot_d;
    logic [WIDTH*DEPTH-1:0]        data_q, data_d;
    logic [CW-1:0]                 count_q, count_d;

    logic                          accept;
    logic [CW-1:0]                 n_words;
    logic [1:0]                    mode_eff;

    // Mode 01 puts slot i in lane i from the LSB. Mode 10 replicates slot 0.
    // Modes 00 and 11 put slot 0 in the MSBs.
    function automatic logic [WIDTH*DEPTH-1:0] pack(
        input logic [1:0]                  m,
        input logic [DEPTH-1:0][WIDTH-1:0] s
    );
        logic [WIDTH*DEPTH-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            case (m)
                2'b01:   r[i*WIDTH +: WIDTH]           = s[i];
                2'b10:   r[i*WIDTH +: WIDTH]           = s[0];
                default: r[(DEPTH-1-i)*WIDTH +: WIDTH] = s[i];
            endcase
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        slot_d   = slot_q;
        data_d   = data_q;
        count_d  = count_q;
        accept   = 1'b0;
        mode_eff = mode_q;
        n_words  = cnt_q;
        case (state_q)
            FILL: begin
                accept  = in_valid;
                n_words = cnt_q + CW'(accept);
                if (accept && cnt_q == '0) begin
                    mode_eff = mode;
                end
                if (accept) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (cnt_q == CW'(i)) begin
                            slot_d[i] = in_data;
                        end
                    end
                    cnt_d  = n_words;
                    mode_d = mode_eff;
                end
                // Pack from the next-state slots so a word accepted this cycle is included.
                if ((accept && cnt_q == CW'(DEPTH-1)) || (flush && n_words != '0)) begin
                    data_d  = pack(mode_eff, slot_d);
                    count_d = (mode_eff == 2'b10) ? CW'(DEPTH) : n_words;
                    state_d = HOLD;
                    cnt_d   = '0;
                    slot_d  = '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            slot_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            slot_q  <= slot_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack (WIDTH=8, DEPTH=4): a table of packed groups
// plus hand-written sequences for reset, backpressure and flush corners.
module tb_vec_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [1:0]  mode;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    vec_pack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mode      (mode),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // fl: 0 = no flush, 1 = flush with the last word, 2 = flush on the cycle after
    typedef struct {
        logic [1:0]  mode_first;
        logic [1:0]  mode_rest;
        int          n;
        logic [31:0] w;
        int          fl;
        logic [31:0] exp_data;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input logic [1:0] m, input logic fl);
        in_valid = 1'b1;
        in_data  = w;
        mode     = m;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic release_group();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release out_valid", 32'(out_valid), 32'd0);
        check("release in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            send(v.w[(3-k)*8 +: 8], (k == 0) ? v.mode_first : v.mode_rest,
                 (v.fl == 1) && (k == v.n - 1));
        end
        if (v.fl == 2) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        check($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd0);
        check($sformatf("vec%0d out_data", idx), out_data, v.exp_data);
        check($sformatf("vec%0d out_count", idx), 32'(out_count), 32'(v.exp_count));
        tick();
        check($sformatf("vec%0d hold data", idx), out_data, v.exp_data);
        release_group();
    endtask

    initial begin
        vecs[0] = '{2'b00, 2'b00, 4, 32'h11223344, 0, 32'h11223344, 3'd4};
        vecs[1] = '{2'b01, 2'b01, 4, 32'h11223344, 0, 32'h44332211, 3'd4};
        vecs[2] = '{2'b10, 2'b10, 4, 32'hA5010203, 0, 32'hA5A5A5A5, 3'd4};
        vecs[3] = '{2'b00, 2'b00, 2, 32'h11220000, 2, 32'h11220000, 3'd2};
        vecs[4] = '{2'b01, 2'b01, 2, 32'h11220000, 2, 32'h00002211, 3'd2};
        vecs[5] = '{2'b00, 2'b00, 3, 32'h11223300, 1, 32'h11223300, 3'd3};
        vecs[6] = '{2'b11, 2'b11, 4, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3'd4};
        vecs[7] = '{2'b10, 2'b10, 1, 32'h5A000000, 2, 32'h5A5A5A5A, 3'd4};
        vecs[8] = '{2'b00, 2'b01, 4, 32'h01020304, 0, 32'h01020304, 3'd4};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 2'b00;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_data", out_data, 32'd0);
        check("reset out_count", 32'(out_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        // Flush with an empty group is ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("empty flush out_valid", 32'(out_valid), 32'd0);
        check("empty flush in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: 55 is offered while the group is held
        send(8'h11, 2'b00, 1'b0);
        send(8'h22, 2'b00, 1'b0);
        send(8'h33, 2'b00, 1'b0);
        send(8'h44, 2'b00, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int c = 0; c < 5; c++) begin
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_data", out_data, 32'h11223344);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("bp 55 slot0 data", out_data, 32'h55000000);
        check("bp 55 slot0 count", 32'(out_count), 32'd1);
        release_group();

        // Reset after two words of a group
        send(8'hAA, 2'b01, 1'b0);
        send(8'hBB, 2'b01, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midgrp rst out_valid", 32'(out_valid), 32'd0);
        check("midgrp rst in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        send(8'h01, 2'b00, 1'b0);
        send(8'h02, 2'b00, 1'b0);
        send(8'h03, 2'b00, 1'b0);
        send(8'h04, 2'b00, 1'b0);
        check("after rst out_valid", 32'(out_valid), 32'd1);
        check("after rst out_data", out_data, 32'h01020304);
        check("after rst out_count", 32'(out_count), 32'd4);

        // Reset while a group is held drops out_valid and clears the outputs
        #2;
        rst_n = 1'b0;
        #1;
        check("hold rst out_valid", 32'(out_valid), 32'd0);
        check("hold rst out_data", out_data, 32'd0);
        check("hold rst out_count", 32'(out_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
